// File: rtl/wbm_initiator.sv
`timescale 1ns/1ps
// Wishbone classic single-transfer initiator: ready/valid command in, one bus cycle, ready/valid response out.
// Define WBM_TIMEOUT_EN to build the no-ACK wait counter and abort path.
module wbm_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic [15:0] txn_count_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wbm_initiator: TIMEOUT_CYCLES must be within 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;
  logic [15:0] txn_q, txn_d;

`ifdef WBM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_err_q, rsp_err_d;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      txn_q       <= '0;
`ifdef WBM_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      txn_q       <= txn_d;
`ifdef WBM_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    txn_d       = txn_q;
`ifdef WBM_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_err_d   = rsp_err_q;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          we_d        = cmd_we_i;
          adr_d       = cmd_adr_i;
          dat_d       = cmd_dat_i;
          sel_d       = cmd_sel_i;
          cyc_d       = 1'b1;
          cmd_ready_d = 1'b0;
          state_d     = BUS;
`ifdef WBM_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      BUS: begin
        // ACK is checked first so it wins over a timeout in the same cycle
        if (wbm_ack_i) begin
          rsp_dat_d   = we_q ? 32'h0 : wbm_dat_i;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          txn_d       = txn_q + 16'd1;
          state_d     = RESP;
`ifdef WBM_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          rsp_dat_d   = 32'h0;
          rsp_err_d   = 1'b1;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          txn_d       = txn_q + 16'd1;
          state_d     = RESP;
        end else begin
          cnt_d       = cnt_q + CNT_W'(1);
`endif
        end
      end
      RESP: begin
        if (rsp_valid_q && rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  assign cmd_ready_o = cmd_ready_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign wbm_sel_o   = sel_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign txn_count_o = txn_q;
`ifdef WBM_TIMEOUT_EN
  assign rsp_err_o   = rsp_err_q;
`else
  assign rsp_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_wbm_initiator.sv
`timescale 1ns/1ps
// Self-checking bench for wbm_initiator: directed scenarios plus randomized transfers
// checked against a transaction-level model (expected data, error flag, transfer count).
module tb_wbm_initiator;
  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        cyc, stb, we_o;
  logic [31:0] adr_o, dat_o;
  logic [3:0]  sel_o;
  logic        ack = 1'b0;
  logic [31:0] sdat = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic [15:0] txn_count;

  int vectors = 0;
  int miscompares = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  wbm_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we_o), .wbm_adr_o(adr_o),
    .wbm_dat_o(dat_o), .wbm_sel_o(sel_o), .wbm_ack_i(ack), .wbm_dat_i(sdat),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err), .txn_count_o(txn_count)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({cmd_ready, cyc, stb, we_o, rsp_valid, rsp_err} !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected %b", {cmd_ready, cyc, stb, we_o, rsp_valid, rsp_err}, 6'b100000);
    end
    vectors++;
    if ({adr_o, dat_o, sel_o, rsp_dat, txn_count} !== 116'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h expected 0", {adr_o, dat_o, sel_o, rsp_dat, txn_count});
    end
    rst_n = 1'b1;
    exp_count = 0;
    @(negedge clk);
    vectors++;
    if ({cmd_ready, cyc, rsp_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_release: got %b expected 100", {cmd_ready, cyc, rsp_valid});
    end
  endtask

  // One full transfer: accept, hold for ack_delay cycles without ACK, ACK, then
  // hold the response for rsp_wait cycles of backpressure before the handshake.
  task automatic do_txn(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int ack_delay, input logic [31:0] rdata,
                        input int rsp_wait, input string name);
    logic [31:0] exp_dat;
    exp_dat = we ? 32'h0 : rdata;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_ready_before: got %b expected 1", name, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; ack = 1'b0;
    @(negedge clk);
    cmd_valid = 1'($urandom_range(0, 1)); cmd_we = 1'($urandom_range(0, 1));
    cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);
    vectors++;
    if ({cyc, stb, we_o, adr_o, dat_o, sel_o, cmd_ready, rsp_valid} !== {2'b11, we, adr, dat, sel, 2'b00}) begin
      miscompares++;
      $display("FAIL %s_bus_start: got %h expected %h", name,
               {cyc, stb, we_o, adr_o, dat_o, sel_o, cmd_ready, rsp_valid}, {2'b11, we, adr, dat, sel, 2'b00});
    end
    for (int k = 0; k < ack_delay; k++) begin
      ack = 1'b0; sdat = $urandom;
      @(negedge clk);
      vectors++;
      if ({cyc, stb, we_o, adr_o, dat_o, sel_o, rsp_valid} !== {2'b11, we, adr, dat, sel, 1'b0}) begin
        miscompares++;
        $display("FAIL %s_bus_hold: cycle %0d got %h expected %h", name, k,
                 {cyc, stb, we_o, adr_o, dat_o, sel_o, rsp_valid}, {2'b11, we, adr, dat, sel, 1'b0});
      end
    end
    ack = 1'b1; sdat = rdata;
    @(negedge clk);
    ack = 1'b0; sdat = $urandom;
    exp_count = (exp_count + 1) % 65536;
    vectors++;
    if ({cyc, stb, rsp_valid, rsp_err, cmd_ready} !== 5'b00100) begin
      miscompares++;
      $display("FAIL %s_rsp_ctrl: got %b expected 00100", name, {cyc, stb, rsp_valid, rsp_err, cmd_ready});
    end
    vectors++;
    if (rsp_dat !== exp_dat) begin
      miscompares++;
      $display("FAIL %s_rsp_dat: got %h expected %h", name, rsp_dat, exp_dat);
    end
    vectors++;
    if (txn_count !== 16'(exp_count)) begin
      miscompares++;
      $display("FAIL %s_count: got %0d expected %0d", name, txn_count, exp_count);
    end
    for (int k = 0; k < rsp_wait; k++) begin
      rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_we = 1'($urandom_range(0, 1));
      cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);
      ack = 1'($urandom_range(0, 1)); sdat = $urandom;
      @(negedge clk);
      vectors++;
      if ({cyc, rsp_valid, rsp_err, cmd_ready, rsp_dat, txn_count} !== {4'b0100, exp_dat, 16'(exp_count)}) begin
        miscompares++;
        $display("FAIL %s_backpressure: cycle %0d got %h expected %h", name, k,
                 {cyc, rsp_valid, rsp_err, cmd_ready, rsp_dat, txn_count}, {4'b0100, exp_dat, 16'(exp_count)});
      end
    end
    rsp_ready = 1'b1; cmd_valid = 1'b0; ack = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    vectors++;
    if ({rsp_valid, cmd_ready, cyc} !== 3'b010) begin
      miscompares++;
      $display("FAIL %s_after_handshake: got %b expected 010", name, {rsp_valid, cmd_ready, cyc});
    end
    $display("txn %s we=%0d adr=%h dat=%h sel=%h ack_delay=%0d rsp_wait=%0d -> rsp=%h err=%0d count=%0d",
             name, we, adr, dat, sel, ack_delay, rsp_wait, rsp_dat, rsp_err, txn_count);
  endtask

  task automatic test_write_delayed_ack();
    do_txn(1'b1, 32'h3000_0004, 32'h1234_5678, 4'hF, 2, 32'hDEAD_BEEF, 0, "write_delayed");
  endtask

  task automatic test_read_immediate();
    do_txn(1'b0, 32'h3000_0010, 32'h0BAD_F00D, 4'hF, 0, 32'hA5A5_1234, 0, "read_immediate");
  endtask

  task automatic test_backpressure();
    do_txn(1'b0, 32'h3000_0020, 32'h0, 4'h3, 1, 32'h5A5A_C3C3, 5, "backpressure");
  endtask

  task automatic test_back_to_back();
    do_txn(1'b1, 32'h3000_0100, 32'h1111_2222, 4'h1, 0, 32'h0, 0, "b2b_0");
    do_txn(1'b0, 32'h3000_0104, 32'h0, 4'hC, 0, 32'h3333_4444, 0, "b2b_1");
  endtask

`ifdef WBM_TIMEOUT_EN
  task automatic test_timeout();
    int stb_cycles;
    logic [31:0] late_dat;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0040; cmd_dat = '0; cmd_sel = 4'hF; ack = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    stb_cycles = 0;
    for (int k = 0; k < 40 && stb === 1'b1; k++) begin
      stb_cycles++;
      @(negedge clk);
    end
    exp_count = (exp_count + 1) % 65536;
    vectors++;
    if (stb_cycles != int'(TMO)) begin
      miscompares++;
      $display("FAIL timeout_stb_width: got %0d expected %0d", stb_cycles, TMO);
    end
    vectors++;
    if ({rsp_valid, rsp_err, rsp_dat, txn_count} !== {2'b11, 32'h0, 16'(exp_count)}) begin
      miscompares++;
      $display("FAIL timeout_rsp: got %h expected %h", {rsp_valid, rsp_err, rsp_dat, txn_count},
               {2'b11, 32'h0, 16'(exp_count)});
    end
    for (int k = 0; k < 2; k++) begin
      late_dat = $urandom;
      ack = 1'b1; sdat = late_dat;
      @(negedge clk);
      vectors++;
      if ({rsp_valid, rsp_err, rsp_dat, cyc, txn_count} !== {2'b11, 32'h0, 1'b0, 16'(exp_count)}) begin
        miscompares++;
        $display("FAIL timeout_late_ack: got %h expected %h", {rsp_valid, rsp_err, rsp_dat, cyc, txn_count},
                 {2'b11, 32'h0, 1'b0, 16'(exp_count)});
      end
    end
    ack = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    vectors++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL timeout_handshake: got %b expected 01", {rsp_valid, cmd_ready});
    end
    $display("txn timeout stb_cycles=%0d err=%0d count=%0d", stb_cycles, rsp_err, txn_count);
  endtask

  task automatic test_ack_timeout_race();
    do_txn(1'b0, 32'h3000_0050, 32'h0, 4'hF, int'(TMO) - 1, 32'hCAFE_0008, 0, "ack_race");
  endtask
`else
  task automatic test_no_timeout();
    do_txn(1'b0, 32'h3000_0060, 32'h0, 4'hF, 299, 32'h0300_0300, 0, "long_wait");
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      do_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
             $urandom_range(0, 5), $urandom, $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_reset_mid_transfer();
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0070; cmd_dat = 32'h7777_7777; cmd_sel = 4'hF; ack = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (cyc !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_in_bus: got %b expected 1", cyc);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_count = 0;
    vectors++;
    if ({cmd_ready, cyc, stb, we_o, rsp_valid, rsp_err} !== 6'b100000) begin
      miscompares++;
      $display("FAIL rst_mid_ctrl: got %b expected 100000", {cmd_ready, cyc, stb, we_o, rsp_valid, rsp_err});
    end
    vectors++;
    if ({adr_o, dat_o, sel_o, rsp_dat, txn_count} !== 116'h0) begin
      miscompares++;
      $display("FAIL rst_mid_data: got %h expected 0", {adr_o, dat_o, sel_o, rsp_dat, txn_count});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_txn(1'b0, 32'h3000_0074, 32'h0, 4'hF, 1, 32'h1357_9BDF, 0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_write_delayed_ack();
    test_read_immediate();
    test_backpressure();
    test_back_to_back();
`ifdef WBM_TIMEOUT_EN
    test_timeout();
    test_ack_timeout_race();
`else
    test_no_timeout();
`endif
    test_random();
    test_reset_mid_transfer();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
